// File: rtl/dft_stepdown_pkg.sv
// Shared definitions for the stepdown-loop DFT probe path: FSM states,
// frame constants and the frame parity helper.
package dft_stepdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b1;

  function automatic int unsigned frame_len(input int unsigned w);
    return w + 2;
  endfunction

  // Zero-extended upper bits leave the XOR unchanged, so any W up to 16 fits.
  function automatic logic odd_parity(input logic [15:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/dft_botsw_status_serializer_if.sv
// Status/handshake bundle between the DFT controller (master) and the
// bottom-switch status serializer (slave).
interface dft_botsw_status_serializer_if #(
  parameter int W = 8
);
  logic [W-1:0] status_in;
  logic         ten_in;
  logic         start;
  logic         sdo;
  logic         ten_out;
  logic         busy;
  logic         done;
  logic [W-1:0] status_filt;

  modport master (
    output status_in, ten_in, start,
    input  sdo, ten_out, busy, done, status_filt
  );

  modport slave (
    input  status_in, ten_in, start,
    output sdo, ten_out, busy, done, status_filt
  );
endinterface

// File: rtl/dft_sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the filtered status
// only takes a new value once the synchronized vector has held for FILT+1 samples.
module dft_sync_filter #(
  parameter int W    = 8,
  parameter int FILT = 3
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [W-1:0] status_in,
  output logic [W-1:0] status_filt
);

  localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sv_q;
  logic [W-1:0] sv_prev_q;
  logic [3:0]   stab_cnt_q;
  logic [W-1:0] filt_q;

  logic sv_same;
  assign sv_same = (sv_q == sv_prev_q);

  // NOTE: every flop here updates with <= so all stages sample the pre-edge
  // values; blocking assignments would collapse the synchronizer chain.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q    <= '0;
      sv_q       <= '0;
      sv_prev_q  <= '0;
      stab_cnt_q <= '0;
      filt_q     <= '0;
    end else begin
      sync1_q   <= status_in;
      sv_q      <= sync1_q;
      sv_prev_q <= sv_q;
      if (!sv_same)                  stab_cnt_q <= '0;
      else if (stab_cnt_q != CNT_MAX) stab_cnt_q <= stab_cnt_q + 4'd1;
      if (sv_same && stab_cnt_q == CNT_MAX) filt_q <= sv_q;
    end
  end

  assign status_filt = filt_q;

endmodule

// File: rtl/dft_botsw_status_serializer.sv
// Captures a filtered bottom-switch status snapshot on request and shifts it
// out as a start bit, W data bits (MSB first) and an odd-parity bit.
module dft_botsw_status_serializer
  import dft_stepdown_pkg::*;
#(
  parameter int W    = 8,
  parameter int DIV  = 4,
  parameter int FILT = 3
) (
  input logic                         CLK,
  input logic                         RSTN,
  dft_botsw_status_serializer_if.slave bus
);

  localparam int FL = frame_len(W);
  localparam int BW = $clog2(FL);

  state_e          state_q, state_d;
  logic [FL-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      div_cnt_q, div_cnt_d;
  logic            sdo_q, ten_out_q, busy_q, done_q;
  logic [W-1:0]    filt;

  dft_sync_filter #(.W(W), .FILT(FILT)) u_filter (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .status_in   (bus.status_in),
    .status_filt (filt)
  );

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      IDLE: if (bus.start && bus.ten_in) state_d = LOAD;
      LOAD, SHIFT: begin
        if (!bus.ten_in) begin
          // Test enable withdrawn: drop the frame silently, no done pulse.
          state_d   = IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else if (state_q == LOAD) begin
          shreg_d   = {START_BIT, filt, odd_parity(16'(filt))};
          bit_cnt_d = BW'(FL - 1);
          div_cnt_d = 8'(DIV - 1);
          state_d   = SHIFT;
        end else if (div_cnt_q != 8'd0) begin
          div_cnt_d = div_cnt_q - 8'd1;
        end else if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
          div_cnt_d = 8'(DIV - 1);
        end else begin
          state_d = DONE;
          shreg_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so they leave flops aligned with state_q.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sdo_q     <= 1'b0;
      ten_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdo_q     <= (state_d == SHIFT) && shreg_d[FL-1];
      ten_out_q <= (state_d == LOAD) || (state_d == SHIFT);
      busy_q    <= (state_d == LOAD) || (state_d == SHIFT);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.sdo         = sdo_q;
  assign bus.ten_out     = ten_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.status_filt = filt;

endmodule
